// File: rtl/reaction_display_pkg.sv
// Shared types, segment codes and the BCD-to-segment lookup for the reaction-timer display.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package reaction_display_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMMIT
    } conv_state_t;

    localparam logic [13:0] MAX_DISPLAY = 14'd9999;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_of(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/reaction_display_bin2bcd_seq.sv
// Sequential double-dabble: 14-bit binary to 4 BCD digits, 16 clocks from start seen in IDLE.
// No backpressure: start is only honoured in IDLE; result regs update atomically in COMMIT.
module bin2bcd_seq
    import reaction_display_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            start,
    input  logic [13:0]     bin,
    output logic            load,
    output bcd_t [3:0]      bcd
);

    conv_state_t state;
    logic [3:0]  iter;
    logic [29:0] sr;
    logic [29:0] sr_adj;

    assign load = (state == LOAD);

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        sr_adj = sr;
        for (int k = 0; k < 4; k++) begin
            if (sr[14 + 4*k +: 4] >= 4'd5) begin
                sr_adj[14 + 4*k +: 4] = sr[14 + 4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            iter  <= '0;
            sr    <= '0;
            bcd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    sr    <= {16'd0, bin};
                    iter  <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr   <= {sr_adj[28:0], 1'b0};
                    iter <= iter + 4'd1;
                    if (iter == 4'd13) state <= COMMIT;
                end
                COMMIT: begin
                    bcd   <= sr[29:14];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/reaction_display.sv
// 4-digit multiplexed seven-segment display of a 14-bit ms value; REACTION_DISPLAY_DP_EN shows "X.XXX".
// Digits settle 16 clocks after a value change, outputs registered one clock behind the scan; no backpressure.
module reaction_display
    import reaction_display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [13:0] i_display_val,
    input  logic        i_display_greeting,
    output logic [3:0]  o_an,
    output logic [7:0]  o_sseg
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [13:0]  last_val;
    logic [13:0]  clamped;
    logic         conv_start;
    logic         conv_load;
    bcd_t [3:0]   bcd;
    logic [CW-1:0] scan_cnt;
    logic [1:0]   digit_idx;
    logic [6:0]   seg_nxt;
    logic         dp_nxt;

    assign clamped    = (i_display_val > MAX_DISPLAY) ? MAX_DISPLAY : i_display_val;
    assign conv_start = (i_display_val != last_val);

    bin2bcd_seq u_conv (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .start   (conv_start),
        .bin     (clamped),
        .load    (conv_load),
        .bcd     (bcd)
    );

    // last_val tracks the raw value so an out-of-range input doesn't retrigger forever.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_val <= '0;
        end else if (conv_load) begin
            last_val <= i_display_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == CW'(REFRESH_CYCLES - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + CW'(1);
        end
    end

`ifdef REACTION_DISPLAY_DP_EN
    always_comb begin
        seg_nxt = seg_of(bcd[digit_idx]);
        dp_nxt  = (digit_idx != 2'd3);
        if (i_display_greeting) begin
            dp_nxt = 1'b1;
            case (digit_idx)
                2'd0:    seg_nxt = SEG_I;
                2'd1:    seg_nxt = SEG_H;
                default: seg_nxt = SEG_BLANK;
            endcase
        end
    end
`else
    logic [3:0] blank;

    // A digit is blank when it and every digit above it are zero; digit0 always shows.
    always_comb begin
        blank[3] = (bcd[3] == 4'd0);
        blank[2] = blank[3] && (bcd[2] == 4'd0);
        blank[1] = blank[2] && (bcd[1] == 4'd0);
        blank[0] = 1'b0;
    end

    always_comb begin
        seg_nxt = blank[digit_idx] ? SEG_BLANK : seg_of(bcd[digit_idx]);
        dp_nxt  = 1'b1;
        if (i_display_greeting) begin
            case (digit_idx)
                2'd0:    seg_nxt = SEG_I;
                2'd1:    seg_nxt = SEG_H;
                default: seg_nxt = SEG_BLANK;
            endcase
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_an   <= 4'hF;
            o_sseg <= 8'hFF;
        end else begin
            o_an   <= ~(4'b0001 << digit_idx);
            o_sseg <= {dp_nxt, seg_nxt};
        end
    end

endmodule
